// File: rtl/hack_pkg.sv
// Shared Hack CPU types and widths.
package hack_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifetch_state_t;

endpackage

// File: rtl/hack_ifetch_if.sv
// Instruction ROM read channel and decode-side instruction channel of the fetch unit.
interface hack_ifetch_if;
  import hack_pkg::*;

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ready;
  logic              rom_rvalid;
  logic [INST_W-1:0] rom_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;

  modport master (
    output rom_req, rom_addr, inst_valid, inst, inst_addr,
    input  rom_ready, rom_rvalid, rom_rdata, inst_ready
  );

  modport slave (
    input  rom_req, rom_addr, inst_valid, inst, inst_addr,
    output rom_ready, rom_rvalid, rom_rdata, inst_ready
  );

endinterface

// File: rtl/hack_ifetch_fifo.sv
// Prefetch FIFO holding {instruction, address}; flush wins over push.
module hack_ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/hack_ifetch.sv
// Hack instruction fetch: in-order ROM requests with credit limit, prefetch buffer, redirect flush.
//   state | meaning
//   RUN   | issuing requests while credits remain, buffering responses
//   DRAIN | waiting out stale responses after a redirect, no requests
module hack_ifetch
  import hack_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  hack_ifetch_if.master     bus
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  ifetch_state_t            state, state_nxt;
  logic [ADDR_W-1:0]        fetch_ptr;
  logic [ADDR_W-1:0]        resp_addr;
  logic [CW-1:0]            inflight, inflight_nxt;
  logic [CW-1:0]            fifo_count;
  logic                     rom_req, inst_valid;
  logic                     accept, push, pop;
  logic                     fifo_empty, fifo_full;
  logic [INST_W+ADDR_W-1:0] fifo_head;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect)
      state_nxt = (inflight_nxt == '0) ? RUN : DRAIN;
    else if (state == DRAIN && inflight_nxt == '0)
      state_nxt = RUN;
  end

  // Credits come from this cycle's counts only; a same-cycle pop frees nothing yet.
  always_comb begin
    rom_req = 1'b0;
    push    = 1'b0;
    case (state)
      RUN: begin
        rom_req = !redirect && (({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS);
        push    = bus.rom_rvalid && !redirect;
      end
      default: ;
    endcase
    if (xrst) rom_req = 1'b0;
    inst_valid = !fifo_empty && !redirect;
  end

  assign accept       = rom_req && bus.rom_ready;
  assign pop          = inst_valid && bus.inst_ready;
  assign inflight_nxt = inflight + CW'(accept) - CW'(bus.rom_rvalid);
  // Outstanding requests are contiguous, so the oldest one sits inflight words behind the pointer.
  assign resp_addr    = fetch_ptr - ADDR_W'(inflight);

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      fetch_ptr <= '0;
      inflight  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect)    fetch_ptr <= redirect_addr;
      else if (accept) fetch_ptr <= fetch_ptr + ADDR_W'(1);
    end
  end

  hack_ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INST_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .xrst  (xrst),
    .push  (push && (!fifo_full || pop)),
    .pop   (pop),
    .flush (redirect),
    .din   ({bus.rom_rdata, resp_addr}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.rom_req    = rom_req;
  assign bus.rom_addr   = fetch_ptr;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = fifo_head[INST_W+ADDR_W-1 -: INST_W];
  assign bus.inst_addr  = fifo_head[ADDR_W-1:0];

endmodule

// File: tb/tb_hack_ifetch.sv
// Self-checking bench for hack_ifetch: latency-programmable ROM model plus queue-level fetch model.
module tb_hack_ifetch;
  import hack_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] addr;
    int          epoch;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = '0;

  hack_ifetch_if bus();

  hack_ifetch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .xrst          (xrst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc, epoch, last_due, first_valid_cyc;
  int          lat_min = 1, lat_max = 1;
  int          n_acc = 0, n_pop = 0;
  req_t        romq[$];
  logic [15:0] mq[$];
  logic [15:0] acc_log[$];
  logic [15:0] pop_log[$];
  logic [15:0] exp_ptr;

  function automatic logic [15:0] romfn(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (romq[i]) if (romq[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    romq.delete();
    mq.delete();
    exp_ptr         = '0;
    epoch           = 0;
    last_due        = -1;
    cyc             = 0;
    first_valid_cyc = -1;
  endtask

  task automatic idle_inputs();
    bus.rom_ready  = 1'b0;
    bus.rom_rvalid = 1'b0;
    bus.rom_rdata  = '0;
    bus.inst_ready = 1'b0;
    redirect       = 1'b0;
    redirect_addr  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rom_req"},    bus.rom_req,    0);
    check_val({tag, "_rom_addr"},   bus.rom_addr,   0);
    check_val({tag, "_inst_valid"}, bus.inst_valid, 0);
    check_val({tag, "_inst"},       bus.inst,       0);
    check_val({tag, "_inst_addr"},  bus.inst_addr,  0);
  endtask

  // Called at a falling edge: reset is raised between edges and the outputs are checked before any clock.
  task automatic reset_midway();
    #2 xrst = 1'b1;
    idle_inputs();
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    xrst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model past the edge.
  task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [15:0] raddr);
    bit   rv, acc, pop, exp_req;
    int   lat;
    req_t e;
    bus.rom_ready  = rdy;
    bus.inst_ready = irdy;
    redirect       = redir;
    redirect_addr  = raddr;
    rv = (romq.size() > 0) && (romq[0].due <= cyc);
    bus.rom_rvalid = rv;
    bus.rom_rdata  = rv ? romfn(romq[0].addr) : 16'($urandom);
    #1;
    exp_req = !redir && (stale_cnt() == 0) && (romq.size() + mq.size() < DEPTH);
    check_val("rom_req", bus.rom_req, exp_req);
    if (bus.rom_req) check_val("rom_addr", bus.rom_addr, exp_ptr);
    check_val("inst_valid", bus.inst_valid, (mq.size() != 0) && !redir);
    if (bus.inst_valid && mq.size() != 0) begin
      check_val("inst_addr", bus.inst_addr, mq[0]);
      check_val("inst", bus.inst, romfn(mq[0]));
    end
    if (bus.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    acc = bus.rom_req && rdy;
    pop = bus.inst_valid && irdy;
    if (pop && mq.size() != 0) begin
      pop_log.push_back(mq[0]);
      mq.delete(0);
      n_pop++;
    end
    if (rv) begin
      e = romq[0];
      romq.delete(0);
      if (e.epoch == epoch && !redir) mq.push_back(e.addr);
    end
    if (acc) begin
      lat     = int'($urandom_range(lat_max, lat_min));
      e.addr  = bus.rom_addr;
      e.epoch = epoch;
      e.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = e.due;
      romq.push_back(e);
      acc_log.push_back(bus.rom_addr);
      exp_ptr++;
      n_acc++;
    end
    if (redir) begin
      mq.delete();
      exp_ptr = raddr;
      epoch++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int a0, p0;
    bit rdy, irdy, redir;
    logic [15:0] raddr;

    idle_inputs();
    model_reset();
    #1 xrst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    xrst = 1'b0;
    model_reset();

    // Streaming with a 1-cycle ROM: first instruction at cycle 2, then one per cycle.
    lat_min = 1; lat_max = 1;
    a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 16'h0000);
    check_val("first_valid_cycle", first_valid_cyc, 2);
    check_val("stream_requests", n_acc - a0, 12);
    check_val("stream_pops", n_pop - p0, 10);

    // Reset mid-stream, then backpressure: exactly DEPTH requests, resume after the first pop.
    reset_midway();
    a0 = n_acc;
    acc_log.delete();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 16'h0000);
    check_val("credit_limit", n_acc - a0, DEPTH);
    check_val("restart_addr", acc_log.size() != 0 ? 32'(acc_log[0]) : 32'hDEAD, 32'h0000);
    cycle(1, 1, 0, 16'h0000);
    check_val("resume_after_pop", bus.rom_req, 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 16'h0000);

    // 3-cycle ROM, redirect with requests in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 16'h0000);
    check_val("inflight_before_redirect", romq.size() != 0, 1);
    acc_log.delete(); pop_log.delete();
    cycle(1, 1, 1, 16'h0100);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 16'h0000);
    check_val("drain_first_req", acc_log.size() != 0 ? 32'(acc_log[0]) : 32'hDEAD, 32'h0100);
    check_val("drain_first_inst", pop_log.size() != 0 ? 32'(pop_log[0]) : 32'hDEAD, 32'h0100);

    // Pointer wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    acc_log.delete();
    cycle(1, 1, 1, 16'hFFFE);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 16'h0000);
    check_val("wrap_0", acc_log.size() > 0 ? 32'(acc_log[0]) : 32'hDEAD, 32'hFFFE);
    check_val("wrap_1", acc_log.size() > 1 ? 32'(acc_log[1]) : 32'hDEAD, 32'hFFFF);
    check_val("wrap_2", acc_log.size() > 2 ? 32'(acc_log[2]) : 32'hDEAD, 32'h0000);

    // Redirect landing on a response and a pop; then a second redirect while draining.
    check_val("rvalid_pending", (romq.size() != 0) && (romq[0].due <= cyc), 1);
    check_val("buffer_nonempty", mq.size() != 0, 1);
    cycle(1, 1, 1, 16'h0300);
    check_val("flush_inst_valid", bus.inst_valid, 0);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 16'h0000);
    acc_log.delete();
    cycle(1, 1, 1, 16'h0100);
    cycle(1, 1, 1, 16'h0200);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 16'h0000);
    check_val("drain_reload_req", acc_log.size() != 0 ? 32'(acc_log[0]) : 32'hDEAD, 32'h0200);

    // Randomized traffic with varying ROM latency and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        lat_min = 1;
        lat_max = int'($urandom_range(4, 1));
      end
      if (i == 1500) reset_midway();
      rdy   = ($urandom_range(3, 0) != 0);
      irdy  = ($urandom_range(2, 0) != 0);
      redir = ($urandom_range(24, 0) == 0);
      raddr = ($urandom_range(1, 0) != 0) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(3, 0));
      cycle(rdy, irdy, redir, raddr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hack_ifetch.md
# hack_ifetch

Instruction fetch unit for the Hack CPU: the consumer side of the program-counter address stream. It keeps its own fetch pointer and issues in-order read requests to the instruction ROM over a ready/valid interface. Returned words are buffered in a small prefetch FIFO and presented to the decode stage with their addresses. Jumps and resets arrive as a redirect, which flushes the buffer and discards stale in-flight responses.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2; also the cap on in-flight plus buffered words
- clk  in  1  clock; all state updates on rising edge
- xrst  in  1  reset; asynchronous, active-high
- redirect  in  1  load fetch pointer from redirect_addr and flush (jump taken or CPU reset)
- redirect_addr  in  16  new fetch address
- rom_req  out  1  read request valid
- rom_addr  out  16  read address; stable while rom_req && !rom_ready
- rom_ready  in  1  ROM accepts request this cycle
- rom_rvalid  in  1  one-cycle pulse per accepted request; in order; ≥1 cycle after acceptance
- rom_rdata  in  16  instruction word, valid with rom_rvalid
- inst_valid  out  1  buffered instruction available
- inst  out  16  instruction at FIFO head
- inst_addr  out  16  ROM address of inst
- inst_ready  in  1  decode consumes head when inst_valid && inst_ready

## Operation
- State machine: RUN and DRAIN. Reset state: RUN.
- Reset values: fetch pointer 0, FIFO empty, inflight 0, rom_req 0, inst_valid 0, inst 0, inst_addr 0.
- RUN:
  - rom_req = !redirect && (inflight + fifo_count < DEPTH).
  - rom_addr = fetch pointer.
  - Acceptance (rom_req && rom_ready): pointer +1, mod 2^16 (0xFFFF wraps to 0x0000); inflight +1.
  - rom_rvalid: push {rom_rdata, address} into FIFO; inflight −1.
- Each FIFO entry stores its address. The address queue is tracked in parallel with inflight.
- Credit check uses current-cycle counts. A pop in the same cycle does not free a credit until the next cycle.
- Pop: inst_valid && inst_ready. inst_valid = FIFO non-empty && !redirect.
- Redirect, any state:
  - FIFO cleared, fetch pointer = redirect_addr, no request issued that cycle.
  - If inflight after this cycle's response is 0: next state RUN. Otherwise: DRAIN.
- DRAIN:
  - rom_req = 0.
  - Every rom_rvalid is discarded and decrements inflight.
  - Return to RUN on the cycle after inflight reaches 0.
  - A further redirect in DRAIN only reloads the pointer.
- Simultaneous events:
  - redirect with rom_rvalid: response dropped but counted.
  - redirect with pop: pop ignored, because inst_valid is 0.
  - push and pop in the same cycle are both legal, including when the FIFO is full and a pop frees the slot.
- inflight counter width: clog2(DEPTH)+1. It never exceeds DEPTH.
- Reset mid-operation: all state returns to reset values immediately. The ROM must also be reset, so no stale responses arrive afterwards.

## Timing
- Request to inst_valid: rom_rvalid at edge N makes inst_valid high after edge N, i.e. one register stage. With a 1-cycle ROM: acceptance at cycle 0, inst_valid at cycle 2.
- Sustained throughput: 1 instruction/cycle when the ROM returns in 1 cycle and DEPTH ≥ 3.
- Redirect to first new request:
  - 1 cycle when nothing is in flight.
  - Otherwise 1 cycle after the last stale response.
- Outputs inst/inst_addr are registered (FIFO head). rom_req is combinational from state, counts and redirect.

## Structure
- Shared package hack_pkg: ADDR_W=16, INST_W=16, ifetch state enum {RUN, DRAIN}.
- Sub-module hack_ifetch_fifo:
  - Synchronous FIFO, DEPTH × 32 bits (inst + addr).
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push.
- Top level holds the FSM, fetch pointer, inflight counter and credit logic.

## Test plan
- Reset, 1-cycle ROM, rom_ready=1, inst_ready=1 → requests to addresses 0,1,2,… every cycle; inst_addr 0 appears at cycle 2, then one instruction per cycle.
- inst_ready=0, DEPTH=4 → exactly 4 requests accepted, then rom_req stays 0; raising inst_ready resumes issue the cycle after the first pop.
- 3-cycle ROM latency, redirect to 0x0100 with 3 in flight → 3 responses discarded, inst_valid stays 0, DRAIN for 3 cycles, then request 0x0100; first inst_addr is 0x0100.
- Fetch pointer starting at 0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000 in order.
- Redirect coinciding with rom_rvalid and with inst_ready=1 → no push, no pop, FIFO empty next cycle; redirect repeated in DRAIN to 0x0200 → fetch resumes at 0x0200.
- xrst asserted mid-stream, between clock edges → outputs go to 0 without a clock edge; after release, fetch restarts at 0x0000.
